// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel-clock divider, freeze enable, sync/blanking and line/frame strobes.
// Optional build macro VGA_LOOKAHEAD_EN makes x/y lead the other outputs by one pixel.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned H_SYNC_POL = 0,
  parameter int unsigned V_SYNC_POL = 0,
  parameter int unsigned CLK_DIV    = 1,
  parameter int unsigned X_W        = 10,
  parameter int unsigned Y_W        = 10
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           h_sync,
  output logic           v_sync,
  output logic           frame_active,
  output logic           pix_en,
  output logic           line_start,
  output logic           frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [X_W-1:0]   H_LAST   = X_W'(H_TOTAL - 1);
  localparam logic [Y_W-1:0]   V_LAST   = Y_W'(V_TOTAL - 1);
  localparam logic [X_W-1:0]   H_VIS    = X_W'(H_ACTIVE);
  localparam logic [Y_W-1:0]   V_VIS    = Y_W'(V_ACTIVE);
  localparam logic [X_W-1:0]   HS_BEG   = X_W'(H_ACTIVE + H_FP);
  localparam logic [X_W-1:0]   HS_END   = X_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [Y_W-1:0]   VS_BEG   = Y_W'(V_ACTIVE + V_FP);
  localparam logic [Y_W-1:0]   VS_END   = Y_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic             HS_ON    = 1'(H_SYNC_POL);
  localparam logic             VS_ON    = 1'(V_SYNC_POL);

`ifdef VGA_LOOKAHEAD_EN
  localparam logic [X_W-1:0]   X_RST    = X_W'(1);
`else
  localparam logic [X_W-1:0]   X_RST    = '0;
`endif

  logic [DIV_W-1:0] div_q, div_d;
  logic [X_W-1:0]   x_q, x_d, x_adv, x_show;
  logic [Y_W-1:0]   y_q, y_d, y_adv, y_show;
  logic             h_sync_q, h_sync_d;
  logic             v_sync_q, v_sync_d;
  logic             frame_active_q, frame_active_d;
  logic             line_start_q, line_start_d;
  logic             frame_start_q, frame_start_d;

  assign pix_en = en & (div_q == DIV_LAST);

  // Raster successor of the current counter position.
  always_comb begin
    x_adv = (x_q == H_LAST) ? '0 : x_q + 1'b1;
    y_adv = y_q;
    if (x_q == H_LAST) begin
      y_adv = (y_q == V_LAST) ? '0 : y_q + 1'b1;
    end
  end

  // Position the registered outputs will describe after the next pix_en edge:
  // the counters already run one pixel ahead in the lookahead build.
`ifdef VGA_LOOKAHEAD_EN
  assign x_show = x_q;
  assign y_show = y_q;
`else
  assign x_show = x_adv;
  assign y_show = y_adv;
`endif

  // NOTE: every signal gets a default first so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    div_d          = div_q;
    x_d            = x_q;
    y_d            = y_q;
    h_sync_d       = h_sync_q;
    v_sync_d       = v_sync_q;
    frame_active_d = frame_active_q;
    line_start_d   = 1'b0;
    frame_start_d  = 1'b0;

    if (en) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    end

    if (pix_en) begin
      x_d            = x_adv;
      y_d            = y_adv;
      h_sync_d       = (x_show >= HS_BEG && x_show < HS_END) ? HS_ON : ~HS_ON;
      v_sync_d       = (y_show >= VS_BEG && y_show < VS_END) ? VS_ON : ~VS_ON;
      frame_active_d = (x_show < H_VIS) && (y_show < V_VIS);
      line_start_d   = (x_show == '0);
      frame_start_d  = (x_show == '0) && (y_show == '0);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q          <= '0;
      x_q            <= X_RST;
      y_q            <= '0;
      h_sync_q       <= ~HS_ON;
      v_sync_q       <= ~VS_ON;
      frame_active_q <= 1'b1;
      line_start_q   <= 1'b0;
      frame_start_q  <= 1'b0;
    end else begin
      div_q          <= div_d;
      x_q            <= x_d;
      y_q            <= y_d;
      h_sync_q       <= h_sync_d;
      v_sync_q       <= v_sync_d;
      frame_active_q <= frame_active_d;
      line_start_q   <= line_start_d;
      frame_start_q  <= frame_start_d;
    end
  end

  assign x            = x_q;
  assign y            = y_q;
  assign h_sync       = h_sync_q;
  assign v_sync       = v_sync_q;
  assign frame_active = frame_active_q;
  assign line_start   = line_start_q;
  assign frame_start  = frame_start_q;

endmodule
